// File: rtl/ahblite_interconnect_n.sv
// rtl/ahblite_interconnect_n.sv - AHB-Lite single-master decoder, response mux and default error slave
// Optional wait-state timeout override: define AHBLITE_TIMEOUT_EN
module ahblite_interconnect_n #(
    parameter int                 NSLV        = 4,
    parameter logic [32*NSLV-1:0] ADDR_BASE   = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [32*NSLV-1:0] ADDR_MASK   = {4{32'hF000_0000}},
    parameter int                 TIMEOUT_CYC = 255
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [31:0]          HADDR,
    input  logic [2:0]           HBURST,
    input  logic                 HMASTLOCK,
    input  logic [3:0]           HPROT,
    input  logic [2:0]           HSIZE,
    input  logic [1:0]           HTRANS,
    input  logic [31:0]          HWDATA,
    input  logic                 HWRITE,
    output logic                 HREADY,
    output logic [31:0]          HRDATA,
    output logic                 HRESP,
    output logic [31:0]          HADDR_S,
    output logic [2:0]           HBURST_S,
    output logic                 HMASTLOCK_S,
    output logic [3:0]           HPROT_S,
    output logic [2:0]           HSIZE_S,
    output logic [1:0]           HTRANS_S,
    output logic [31:0]          HWDATA_S,
    output logic                 HWRITE_S,
    output logic                 HREADY_S,
    output logic [NSLV-1:0]      HSEL_S,
    input  logic [NSLV-1:0]      HREADYOUT_S,
    input  logic [NSLV-1:0]      HRESP_S,
    input  logic [32*NSLV-1:0]   HRDATA_S,
    output logic                 TIMEOUT_IRQ
);

    generate
        if (NSLV < 1 || NSLV > 16) begin : g_bad_nslv
            $error("NSLV must be in 1..16");
        end
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
            $error("TIMEOUT_CYC must be in 1..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    logic [NSLV:0] addr_sel;
    logic [NSLV:0] dsel;
    logic          addr_hit;
    logic          mux_ready;
    logic          mux_resp;
    logic [31:0]   mux_rdata;
    logic          def_ready;
    logic          def_resp;
    logic          def_req;
    ds_state_t     ds_state;
    ds_state_t     ds_next;

    assign HADDR_S     = HADDR;
    assign HBURST_S    = HBURST;
    assign HMASTLOCK_S = HMASTLOCK;
    assign HPROT_S     = HPROT;
    assign HSIZE_S     = HSIZE;
    assign HTRANS_S    = HTRANS;
    assign HWDATA_S    = HWDATA;
    assign HWRITE_S    = HWRITE;
    assign HREADY_S    = HREADY;

    // Priority decode: the lowest matching index claims the address; bit NSLV is the default slave.
    always_comb begin
        addr_sel = '0;
        addr_hit = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (!addr_hit && ((HADDR & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32])) begin
                addr_sel[i] = 1'b1;
                addr_hit    = 1'b1;
            end
        end
        addr_sel[NSLV] = !addr_hit;
    end

    assign HSEL_S = addr_sel[NSLV-1:0];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dsel <= '0;
        end else if (HREADY) begin
            dsel <= addr_sel;
        end
    end

    assign def_ready = (ds_state != DS_ERR1);
    assign def_resp  = (ds_state != DS_IDLE);
    assign def_req   = HREADY && addr_sel[NSLV] && HTRANS[1];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ds_state <= DS_IDLE;
        end else begin
            ds_state <= ds_next;
        end
    end

    always_comb begin
        ds_next = ds_state;
        unique case (ds_state)
            DS_IDLE: if (def_req) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = def_req ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    // An empty data-phase select (after reset) behaves as a completed OKAY transfer.
    always_comb begin
        mux_ready = 1'b1;
        mux_resp  = 1'b0;
        mux_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (dsel[i]) begin
                mux_ready = HREADYOUT_S[i];
                mux_resp  = HRESP_S[i];
                mux_rdata = HRDATA_S[32*i +: 32];
            end
        end
        if (dsel[NSLV]) begin
            mux_ready = def_ready;
            mux_resp  = def_resp;
        end
    end

    assign HRDATA = mux_rdata;

`ifdef AHBLITE_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);

    logic [15:0] to_count;
    logic        to_first;
    logic        to_second;
    logic        mapped_owned;

    assign mapped_owned = |dsel[NSLV-1:0];
    assign to_first     = (to_count == TO_LIMIT);

    // Reaching the limit forces a two-cycle ERROR response in place of the stuck slave.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            to_count  <= '0;
            to_second <= 1'b0;
        end else if (to_first) begin
            to_count  <= '0;
            to_second <= 1'b1;
        end else begin
            to_second <= 1'b0;
            if (HREADY) begin
                to_count <= '0;
            end else if (mapped_owned) begin
                to_count <= to_count + 16'd1;
            end
        end
    end

    assign HREADY      = to_first ? 1'b0 : (to_second ? 1'b1 : mux_ready);
    assign HRESP       = to_first | to_second | mux_resp;
    assign TIMEOUT_IRQ = to_second;
`else
    assign HREADY      = mux_ready;
    assign HRESP       = mux_resp;
    assign TIMEOUT_IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_ahblite_interconnect_n.sv
// tb/tb_ahblite_interconnect_n.sv - directed and randomized bench for ahblite_interconnect_n
module tb_ahblite_interconnect_n;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [31:0]  HADDR;
    logic [2:0]   HBURST;
    logic         HMASTLOCK;
    logic [3:0]   HPROT;
    logic [2:0]   HSIZE;
    logic [1:0]   HTRANS;
    logic [31:0]  HWDATA;
    logic         HWRITE;
    logic         HREADY;
    logic [31:0]  HRDATA;
    logic         HRESP;
    logic [31:0]  HADDR_S;
    logic [2:0]   HBURST_S;
    logic         HMASTLOCK_S;
    logic [3:0]   HPROT_S;
    logic [2:0]   HSIZE_S;
    logic [1:0]   HTRANS_S;
    logic [31:0]  HWDATA_S;
    logic         HWRITE_S;
    logic         HREADY_S;
    logic [3:0]   HSEL_S;
    logic [3:0]   HREADYOUT_S;
    logic [3:0]   HRESP_S;
    logic [127:0] HRDATA_S;
    logic         TIMEOUT_IRQ;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 HCLK = ~HCLK;

    // Slave 3 overlaps slaves 0..2 (a[31]==0) so lowest-index priority is exercised.
    ahblite_interconnect_n #(
        .NSLV        (4),
        .ADDR_BASE   ({32'h0000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .ADDR_MASK   ({32'h8000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT_CYC (8)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HBURST      (HBURST),
        .HMASTLOCK   (HMASTLOCK),
        .HPROT       (HPROT),
        .HSIZE       (HSIZE),
        .HTRANS      (HTRANS),
        .HWDATA      (HWDATA),
        .HWRITE      (HWRITE),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .HRESP       (HRESP),
        .HADDR_S     (HADDR_S),
        .HBURST_S    (HBURST_S),
        .HMASTLOCK_S (HMASTLOCK_S),
        .HPROT_S     (HPROT_S),
        .HSIZE_S     (HSIZE_S),
        .HTRANS_S    (HTRANS_S),
        .HWDATA_S    (HWDATA_S),
        .HWRITE_S    (HWRITE_S),
        .HREADY_S    (HREADY_S),
        .HSEL_S      (HSEL_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA_S    (HRDATA_S),
        .TIMEOUT_IRQ (TIMEOUT_IRQ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Address map of the instance: slaves 0..2 by top nibble, slave 3 for the rest of the lower half.
    function automatic int decode(input logic [31:0] a);
        if (a[31:28] == 4'h0) return 0;
        if (a[31:28] == 4'h1) return 1;
        if (a[31:28] == 4'h2) return 2;
        if (a[31] == 1'b0)    return 3;
        return 4;
    endfunction

    logic [3:0]  ro;
    logic [3:0]  rs;
    logic [31:0] rd [4];
    int          owner;
    int          err_beat;
    int          waits;
    bit          prev_ready;
    logic        er;
    logic        es;
    logic [31:0] ed;
    int          d;
    logic [31:0] exp_sel;

    initial begin
        HRESETn     = 1'b0;
        HADDR       = 32'h1000_0000;
        HBURST      = 3'd0;
        HMASTLOCK   = 1'b0;
        HPROT       = 4'h3;
        HSIZE       = 3'd2;
        HTRANS      = 2'b00;
        HWDATA      = 32'h0;
        HWRITE      = 1'b0;
        HREADYOUT_S = 4'hF;
        HRESP_S     = 4'h0;
        HRDATA_S    = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
        tick();
        tick();
        chk("rst_hready", HREADY, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_irq", TIMEOUT_IRQ, 0);

        // zero-wait read from slave 1
        HRESETn = 1'b1;
        HRDATA_S[63:32] = 32'hA5A5_0001;
        HADDR  = 32'h1000_0010;
        HTRANS = 2'b10;
        #1;
        chk("rd1_hsel", HSEL_S, 4'b0010);
        tick();
        HADDR  = 32'hF000_0000;
        HTRANS = 2'b00;
        #1;
        chk("rd1_hrdata", HRDATA, 32'hA5A5_0001);
        chk("rd1_hready", HREADY, 1);
        chk("rd1_hresp", HRESP, 0);

        // NONSEQ write to an unmapped address
        HADDR  = 32'h9000_0000;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        #1;
        chk("unm_hsel", HSEL_S, 0);
        tick();
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        #1;
        chk("unm_err1_hready", HREADY, 0);
        chk("unm_err1_hresp", HRESP, 1);
        chk("unm_err1_hrdata", HRDATA, 0);
        tick();
        chk("unm_err2_hready", HREADY, 1);
        chk("unm_err2_hresp", HRESP, 1);
        chk("unm_err2_hready_s", HREADY_S, 1);
        tick();
        chk("unm_done_hready", HREADY, 1);
        chk("unm_done_hresp", HRESP, 0);

        // IDLE and BUSY to unmapped complete OKAY
        HADDR  = 32'hF000_0000;
        HTRANS = 2'b00;
        tick();
        chk("idle_unm_hready", HREADY, 1);
        chk("idle_unm_hresp", HRESP, 0);
        HTRANS = 2'b01;
        tick();
        chk("busy_unm_hready", HREADY, 1);
        chk("busy_unm_hresp", HRESP, 0);
        HTRANS = 2'b00;

        // decode priority and boundaries
        HADDR = 32'h0000_0004; #1; chk("dec_overlap_s0", HSEL_S, 4'b0001);
        HADDR = 32'h3000_0000; #1; chk("dec_s3_low", HSEL_S, 4'b1000);
        HADDR = 32'h7FFF_FFFC; #1; chk("dec_s3_high", HSEL_S, 4'b1000);
        HADDR = 32'h8000_0000; #1; chk("dec_unmapped", HSEL_S, 4'b0000);
        HADDR = 32'h2FFF_FFFF; #1; chk("dec_s2_top", HSEL_S, 4'b0100);

        // slave 0 with 3 wait states followed by slave 2
        HRDATA_S[31:0]  = 32'h0000_AAAA;
        HRDATA_S[95:64] = 32'h2222_2222;
        HADDR  = 32'h0000_0100;
        HTRANS = 2'b10;
        tick();
        HREADYOUT_S[0] = 1'b0;
        HADDR  = 32'h2000_0000;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_wait_hsel", HSEL_S, 4'b0100);
            chk("b2b_wait_hready", HREADY, 0);
            chk("b2b_wait_hrdata", HRDATA, 32'h0000_AAAA);
            tick();
        end
        HREADYOUT_S[0] = 1'b1;
        #1;
        chk("b2b_s0_hready", HREADY, 1);
        chk("b2b_s0_hrdata", HRDATA, 32'h0000_AAAA);
        tick();
        HTRANS = 2'b00;
        #1;
        chk("b2b_s2_hrdata", HRDATA, 32'h2222_2222);
        chk("b2b_s2_hready", HREADY, 1);

        // slave 3 stuck not-ready
        HREADYOUT_S[3] = 1'b0;
        HADDR  = 32'h4000_0000;
        HTRANS = 2'b10;
        tick();
        HADDR  = 32'h1000_0000;
        HTRANS = 2'b00;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_hready", HREADY, 0);
            chk("to_wait_irq", TIMEOUT_IRQ, 0);
            tick();
        end
`ifdef AHBLITE_TIMEOUT_EN
        chk("to_c1_hready", HREADY, 0);
        chk("to_c1_hresp", HRESP, 1);
        chk("to_c1_irq", TIMEOUT_IRQ, 0);
        tick();
        chk("to_c2_hready", HREADY, 1);
        chk("to_c2_hresp", HRESP, 1);
        chk("to_c2_hready_s", HREADY_S, 1);
        chk("to_c2_irq", TIMEOUT_IRQ, 1);
        tick();
        chk("to_after_hready", HREADY, 1);
        chk("to_after_hresp", HRESP, 0);
        chk("to_after_irq", TIMEOUT_IRQ, 0);
`else
        for (int i = 0; i < 20; i++) begin
            chk("nto_hready", HREADY, 0);
            chk("nto_irq", TIMEOUT_IRQ, 0);
            tick();
        end
`endif
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        HREADYOUT_S = 4'hF;
        #1;
        chk("rst_abandon_hready", HREADY, 1);
        chk("rst_abandon_hresp", HRESP, 0);

        // reset during the first error cycle
        HADDR  = 32'h9000_0000;
        HTRANS = 2'b10;
        tick();
        HTRANS = 2'b00;
        #1;
        chk("rst_err1_hready", HREADY, 0);
        chk("rst_err1_hresp", HRESP, 1);
        HRESETn = 1'b0;
        tick();
        chk("rst_err1_after_hready", HREADY, 1);
        chk("rst_err1_after_hresp", HRESP, 0);
        HRESETn = 1'b1;
        tick();
        chk("rst_err1_noerr2_hready", HREADY, 1);
        chk("rst_err1_noerr2_hresp", HRESP, 0);

        // randomized traffic against a transfer-level model
        HRESETn = 1'b0;
        tick();
        HRESETn    = 1'b1;
        owner      = -1;
        err_beat   = 0;
        waits      = 0;
        prev_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (prev_ready) begin
                HADDR     = $urandom;
                HTRANS    = 2'($urandom_range(0, 3));
                HWRITE    = 1'($urandom_range(0, 1));
                HBURST    = 3'($urandom_range(0, 7));
                HSIZE     = 3'($urandom_range(0, 2));
                HPROT     = 4'($urandom_range(0, 15));
                HMASTLOCK = 1'($urandom_range(0, 1));
            end
            HWDATA = $urandom;
            for (int i = 0; i < 4; i++) begin
                ro[i] = ($urandom_range(0, 3) != 0);
                rs[i] = ($urandom_range(0, 7) == 0);
                rd[i] = $urandom;
            end
            if (owner >= 0 && owner < 4 && waits >= 3) ro[owner] = 1'b1;
            HREADYOUT_S = ro;
            HRESP_S     = rs;
            HRDATA_S    = {rd[3], rd[2], rd[1], rd[0]};
            #1;
            if (owner < 0) begin
                er = 1'b1; es = 1'b0; ed = 32'h0;
            end else if (owner < 4) begin
                er = ro[owner]; es = rs[owner]; ed = rd[owner];
            end else begin
                er = (err_beat != 1); es = (err_beat != 0); ed = 32'h0;
            end
            d = decode(HADDR);
            exp_sel = (d < 4) ? (32'd1 << d) : 32'd0;
            chk("rnd_hready", HREADY, er);
            chk("rnd_hresp", HRESP, es);
            chk("rnd_hrdata", HRDATA, ed);
            chk("rnd_hsel", HSEL_S, exp_sel);
            chk("rnd_hready_s", HREADY_S, er);
            chk("rnd_haddr_s", HADDR_S, HADDR);
            chk("rnd_hwdata_s", HWDATA_S, HWDATA);
            chk("rnd_ctrl_s", {HTRANS_S, HWRITE_S, HBURST_S, HSIZE_S, HPROT_S, HMASTLOCK_S},
                {HTRANS, HWRITE, HBURST, HSIZE, HPROT, HMASTLOCK});
            chk("rnd_irq", TIMEOUT_IRQ, 0);
            if (er) begin
                owner    = d;
                err_beat = (d == 4 && HTRANS[1]) ? 1 : 0;
                waits    = 0;
            end else if (owner == 4 && err_beat == 1) begin
                err_beat = 2;
            end else begin
                waits++;
            end
            prev_ready = er;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahblite_interconnect_n.md
AHBLITE_INTERCONNECT_N -- requirements
Module: ahblite_interconnect_n

Interface
REQ-001 The block SHALL have parameter NSLV, default 4, giving the number of decoded slaves (1..16).
REQ-002 The block SHALL have parameter ADDR_BASE, default {0x4000_0000,0x2000_0000,0x1000_0000,0x0000_0000}, a packed 32*NSLV base vector; slice i belongs to slave i.
REQ-003 The block SHALL have parameter ADDR_MASK, default {4{0xF000_0000}}, a packed 32*NSLV mask vector.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 255, giving the wait-state limit in cycles (1..65535).
REQ-005 HCLK  in  1  sole clock; all state updates on the rising edge.
REQ-006 HRESETn  in  1  reset, synchronous, active-low.
REQ-007 HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE  in  32/3/1/4/3/2/32/1  master address and data phase.
REQ-008 HREADY  out  1  transfer-complete to master.
REQ-009 HRDATA  out  32  read data to master.
REQ-010 HRESP  out  1  0=OKAY, 1=ERROR.
REQ-011 HADDR_S, HBURST_S, HMASTLOCK_S, HPROT_S, HSIZE_S, HTRANS_S, HWDATA_S, HWRITE_S  out  same widths as master  combinational broadcast copies.
REQ-012 HREADY_S  out  1  broadcast of HREADY.
REQ-013 HSEL_S  out  NSLV  one-hot slave select.
REQ-014 HREADYOUT_S  in  NSLV  per-slave ready.
REQ-015 HRESP_S  in  NSLV  per-slave response.
REQ-016 HRDATA_S  in  32*NSLV  per-slave read data, slice i = slave i.
REQ-017 TIMEOUT_IRQ  out  1  one-cycle pulse on forced termination.

Function
REQ-018 Slave i SHALL match when (HADDR & ADDR_MASK[i]) == ADDR_BASE[i]; on overlap the lowest index wins; with no match the internal default slave is selected.
REQ-019 HSEL_S SHALL be combinational from HADDR, independent of HTRANS; at most one bit high; all zero when the default slave is selected.
REQ-020 A data-phase select register (NSLV+1 bits, one-hot including the default) SHALL load the address-phase decode on every cycle with HREADY=1 and hold while HREADY=0.
REQ-021 HREADY, HRESP, HRDATA SHALL be muxed combinationally from the data-phase-selected source; with the register all zero: HREADY=1, HRESP=0, HRDATA=0.
REQ-022 The default slave FSM SHALL have states IDLE, ERR1, ERR2; IDLE->ERR1 when HREADY=1, default selected, HTRANS[1]=1; ERR1->ERR2 unconditionally; ERR2->ERR1 if the same condition holds, else IDLE.
REQ-023 The default slave SHALL drive: IDLE HREADYOUT=1/HRESP=0; ERR1 HREADYOUT=0/HRESP=1; ERR2 HREADYOUT=1/HRESP=1; HRDATA=0 always.
REQ-024 An IDLE or BUSY transfer to an unmapped address SHALL complete zero-wait with OKAY.
REQ-025 Throughput SHALL be zero added wait states and zero added latency for mapped slaves.

Reset
REQ-026 With HRESETn=0 at an HCLK edge: data-phase select cleared, FSM=IDLE, timeout counter=0, TIMEOUT_IRQ=0; hence HREADY=1, HRESP=0, HRDATA=0 in the following cycle.
REQ-027 Reset asserted mid-transfer or mid-ERROR SHALL abandon it; no response completes after reset.

Configuration
REQ-028 With macro AHBLITE_TIMEOUT_EN defined: a 16-bit counter SHALL count consecutive cycles with HREADY=0 while a mapped slave owns the data phase; clear on HREADY=1.
REQ-029 With AHBLITE_TIMEOUT_EN, on count reaching TIMEOUT_CYC the block SHALL override the mux: cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1 (also on HREADY_S); TIMEOUT_IRQ pulses in cycle 2; the data-phase select then loads normally.
REQ-030 Without AHBLITE_TIMEOUT_EN: no counter, no override, TIMEOUT_IRQ tied to 0, and slave waits are unbounded.

Verification
REQ-031 Reset, NONSEQ read 0x1000_0010, slave1 HRDATA=0xA5A5_0001 zero-wait -> HSEL_S=0b0010 in address phase; next cycle HRDATA=0xA5A5_0001, HREADY=1, HRESP=0.
REQ-032 NONSEQ write 0x9000_0000 (unmapped) -> HSEL_S=0; next two cycles HREADY/HRESP = 0/1 then 1/1; HRDATA=0.
REQ-033 Back-to-back NONSEQ slave0 then slave2, slave0 inserts 3 wait states -> HSEL_S=0b0100 held during waits; slave2 response muxed only after slave0 completes.
REQ-034 IDLE to 0xF000_0000 -> HREADY=1, HRESP=0, no ERROR cycle.
REQ-035 AHBLITE_TIMEOUT_EN, TIMEOUT_CYC=8, slave3 HREADYOUT stuck 0 -> 8 wait cycles, then 0/1, 1/1, TIMEOUT_IRQ=1 for one cycle; without macro HREADY stays 0 indefinitely, TIMEOUT_IRQ=0.
REQ-036 HRESETn=0 during ERR1 -> next cycle HREADY=1, HRESP=0, FSM=IDLE.
